opsum_drain: RTL and testbench

- Downstream drain stage for the PE output-psum FIFO.
- Pops 64-bit opsum words, each packing four 16-bit signed psums, and unpacks them into a 16-bit valid/ready stream toward the GLB/NoC.
- Can apply ReLU to each psum on the way out.
- Counts the words a configured layer produces and signals completion.

---
 rtl/pe_pkg.sv | 7 +
 rtl/psum_lane_mux.sv | 19 +
 rtl/opsum_drain.sv | 99 +++++++++
 tb/tb_opsum_drain.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared types for the opsum drain (FSM states, lane count, psum lane type)
package pe_pkg;
  localparam int LANES = 4;
  localparam int PSUM_W = 16;
  typedef logic [PSUM_W-1:0] psum_t;
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
endpackage

// File: rtl/psum_lane_mux.sv
// psum_lane_mux: selects one psum lane of a packed opsum word, optional ReLU
//   word: packed lanes, lane 0 in the low bits | lane: lane index
//   relu_en: zero negative lanes | data: selected lane
module psum_lane_mux
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [LANES*DATA_WIDTH-1:0] word,
  input  logic [1:0]                  lane,
  input  logic                        relu_en,
  output logic [DATA_WIDTH-1:0]       data
);
  logic [DATA_WIDTH-1:0] slice;
  always_comb begin
    slice = word[lane*DATA_WIDTH +: DATA_WIDTH];
    data = (relu_en && slice[DATA_WIDTH-1]) ? '0 : slice;
  end
endmodule

// File: rtl/opsum_drain.sv
// opsum_drain: pops packed opsum words from the PE FIFO and streams them out lane by lane
//   clk, reset (async, active-low) | configure, F, n, p, relu_en: layer setup pulse
//   opsum, opsum_fifo_empty, pop_opsum: FWFT PE FIFO side
//   out_data, out_valid, out_ready: lane stream | busy, done: layer status
module opsum_drain
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_WIDTH_PSUM = 64,
  parameter int F_WIDTH         = 6,
  parameter int n_WIDTH         = 3,
  parameter int p_WIDTH         = 5,
  parameter int CNT_WIDTH       = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       configure,
  input  logic [F_WIDTH-1:0]         F,
  input  logic [n_WIDTH-1:0]         n,
  input  logic [p_WIDTH-1:0]         p,
  input  logic                       relu_en,
  input  logic [DATA_WIDTH_PSUM-1:0] opsum,
  input  logic                       opsum_fifo_empty,
  output logic                       pop_opsum,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);
  state_t state, state_nx;
  logic [DATA_WIDTH_PSUM-1:0] word_reg;
  logic [1:0] lane;
  logic [CNT_WIDTH-1:0] word_cnt, total_words, cfg_words;
  logic relu_q, zero_done, more;
  logic [DATA_WIDTH-1:0] lane_data;
  assign cfg_words = (CNT_WIDTH'(p) * CNT_WIDTH'(n) * CNT_WIDTH'(F)) >> 2;
  assign more = word_cnt != total_words;
  assign out_data = (state == EMIT) ? lane_data : '0;
  psum_lane_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .word(word_reg[LANES*DATA_WIDTH-1:0]),
    .lane(lane),
    .relu_en(relu_q),
    .data(lane_data)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    pop_opsum = 1'b0;
    out_valid = 1'b0;
    busy = 1'b0;
    done = zero_done;
    case (state)
      IDLE: state_nx = (configure && cfg_words != '0) ? FETCH : IDLE;
      FETCH: begin
        busy = 1'b1;
        pop_opsum = !opsum_fifo_empty;
        state_nx = opsum_fifo_empty ? FETCH : EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        out_valid = 1'b1;
        // the lane-3 accept either finishes, refills in place (no bubble) or waits in FETCH
        if (out_ready && lane == 2'd3) begin
          pop_opsum = more && !opsum_fifo_empty;
          state_nx = !more ? DONE : (opsum_fifo_empty ? FETCH : EMIT);
        end
      end
      DONE: begin
        done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      word_reg <= '0;
      lane <= '0;
      word_cnt <= '0;
      total_words <= '0;
      relu_q <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= state == IDLE && configure && cfg_words == '0;
      if (state == IDLE && configure) begin
        relu_q <= relu_en;
        total_words <= cfg_words;
        word_cnt <= '0;
      end
      if (pop_opsum) begin
        word_reg <= opsum;
        lane <= '0;
        word_cnt <= word_cnt + 1'b1;
      end else if (out_valid && out_ready) lane <= lane + 1'b1;
    end
endmodule

// File: tb/tb_opsum_drain.sv
// tb_opsum_drain: randomized self-checking bench for opsum_drain against a FIFO/lane-stream model
module tb_opsum_drain;
  logic clk = 1'b0, reset = 1'b0, configure = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
  logic [5:0] F = '0;
  logic [2:0] n = '0;
  logic [4:0] p = '0;
  logic [63:0] opsum;
  logic opsum_fifo_empty, pop_opsum, out_valid, busy, done;
  logic [15:0] out_data;
  logic [63:0] mem [0:2047];
  logic [10:0] rd = '0, wr = '0;
  int starve = 0;
  bit starve_mode = 0, rand_ready = 0, relu_m = 0, hold = 0, done_seen = 0, hit = 0;
  int base = 0, total = 0, idx = 0, pops = 0, cyc = 0, last_acc = 0, last_pop = -1, first_valid = -1;
  logic [15:0] hold_data = '0;
  logic [15:0] acc_log [$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  assign opsum = mem[rd];
  assign opsum_fifo_empty = (rd == wr) || (starve > 0);

  opsum_drain dut (
    .clk(clk), .reset(reset), .configure(configure), .F(F), .n(n), .p(p), .relu_en(relu_en),
    .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty), .pop_opsum(pop_opsum),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // k-th psum of word w as a signed value, clamped at zero when ReLU is on
  function automatic logic [15:0] expect_lane(logic [63:0] w, int k, bit r);
    logic signed [15:0] s;
    s = w[k*16 +: 16];
    return (r && s < 0) ? 16'h0 : s;
  endfunction

  always @(posedge clk)
    if (pop_opsum && !opsum_fifo_empty) begin
      rd <= rd + 11'd1;
      starve <= starve_mode ? 5 : 0;
    end else if (starve > 0) starve <= starve - 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk)
    if (reset) begin
      cyc++;
      if (pop_opsum) begin
        chk("pop_while_empty", opsum_fifo_empty, 0);
        chk("pop_beyond_total", pops < total, 1);
      end
      if (out_valid) begin
        chk("valid_with_word", idx < 4 * pops, 1);
        if (first_valid < 0) first_valid = cyc;
        chk("lane_data", out_data, expect_lane(mem[11'(base + idx / 4)], idx % 4, relu_m));
        if (hold) chk("hold_data", out_data, hold_data);
        if (out_ready) begin
          acc_log.push_back(out_data);
          idx++;
          last_acc = cyc;
          hold = 0;
        end else begin
          hold = 1;
          hold_data = out_data;
        end
      end else if (hold) begin
        chk("hold_valid", out_valid, 1);
        hold = 0;
      end
      if (done) begin
        chk("busy_at_done", busy, 0);
        if (total > 0) begin
          chk("lanes_at_done", idx, 4 * total);
          chk("pops_at_done", pops, total);
          chk("done_latency", cyc, last_acc + 1);
          if (!rand_ready && !starve_mode) chk("b2b_span", cyc - first_valid, 4 * total);
        end
        done_seen = 1;
      end
      if (pop_opsum && !opsum_fifo_empty) begin
        if (!rand_ready && !starve_mode && last_pop >= 0) chk("pop_gap", cyc - last_pop, 4);
        last_pop = cyc;
        pops++;
      end
    end

  task automatic push(logic [63:0] w);
    mem[wr] = w;
    wr = wr + 11'd1;
  endtask

  task automatic model_start(int t, bit rl, bit rr, bit sv);
    base = int'(rd);
    total = t;
    relu_m = rl;
    idx = 0;
    pops = 0;
    hold = 0;
    last_pop = -1;
    first_valid = -1;
    done_seen = 0;
    acc_log.delete();
    rand_ready = rr;
    starve_mode = sv;
  endtask

  task automatic cfg(int pp, int nn, int ff, bit rl);
    @(posedge clk);
    #1 configure = 1'b1;
    p = 5'(pp);
    n = 3'(nn);
    F = 6'(ff);
    relu_en = rl;
    @(posedge clk);
    #1 configure = 1'b0;
  endtask

  task automatic run_layer(int pp, int nn, int ff, bit rl, bit rr, bit sv, bit mid);
    int t;
    t = ((pp * nn * ff) & 32'h3fff) >> 2;
    for (int i = int'(wr) - int'(rd); i < t; i++) push({$urandom, $urandom});
    model_start(t, rl, rr, sv);
    cfg(pp, nn, ff, rl);
    if (t == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_pop", pop_opsum, 0);
      chk("zero_busy", busy, 0);
      @(negedge clk);
      chk("zero_done_pulse", done, 0);
    end else begin
      if (mid) begin
        repeat (6) @(posedge clk);
        #1 configure = 1'b1;
        p = 5'd4;
        n = 3'd1;
        F = 6'd4;
        relu_en = !rl;
        @(posedge clk);
        #1 configure = 1'b0;
      end
      for (int c = 0; c < 20000 && !done_seen; c++) @(posedge clk);
      chk("layer_done", done_seen, 1);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
    end
    rand_ready = 0;
    starve_mode = 0;
  endtask

  task automatic check_log(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    logic [15:0] e [4];
    e = '{a, b, c, d};
    chk("log_size", acc_log.size(), 4);
    if (acc_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("literal_lane", acc_log[i], e[i]);
  endtask

  initial begin
    #1;
    chk("rst_pop", pop_opsum, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    push(64'h0004_0003_0002_0001);
    run_layer(4, 1, 1, 0, 0, 0, 0);
    check_log(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    push(64'h7FFF_8000_FFFF_0005);
    run_layer(4, 1, 1, 1, 0, 0, 0);
    check_log(16'h0005, 16'h0000, 16'h0000, 16'h7FFF);
    run_layer(16, 4, 13, 0, 0, 0, 0);
    chk("full_layer_pops", pops, 208);
    run_layer(8, 2, 3, 1, 1, 1, 0);
    run_layer(12, 3, 10, 0, 1, 0, 1);
    run_layer(16, 4, 13, 1, 0, 0, 1);
    run_layer(4, 2, 0, 0, 0, 0, 0);
    push({$urandom, $urandom});
    model_start(1, 0, 0, 0);
    cfg(4, 1, 1, 0);
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      #2 hit = (idx == 3);
    end
    chk("reached_lane2", hit, 1);
    reset = 1'b0;
    idx = 0;
    pops = 0;
    total = 0;
    hold = 0;
    #1;
    chk("abort_pop", pop_opsum, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(posedge clk);
    wr = rd;
    @(negedge clk);
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset_valid", out_valid, 0);
    end
    push(64'h8001_1234_0000_FFFE);
    run_layer(4, 1, 1, 0, 0, 0, 0);
    check_log(16'hFFFE, 16'h0000, 16'h1234, 16'h8001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
